mem_stage: RTL and testbench

Memory-access pipeline stage between the execute stage and the write-back stage. It accepts EX results and issued data-SRAM load/store requests, waits for the SRAM-like `data_ok` response, and aligns and extends load data (lb/lbu/lh/lhu/lw/lwl/lwr). It buffers a response when WB stalls and swallows responses that belong to flushed instructions. It passes exception and CP0 fields to WB unchanged, and provides a forwarding bus to ID.

---
 rtl/mem_stage_pkg.sv | 52 +++++
 rtl/mem_load_align.sv | 66 ++++++
 rtl/mem_stage.sv | 127 ++++++++++++
 tb/tb_mem_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: bus widths, load-op bit positions and the packed layouts of
// the EX->MS and MS->WS buses shared by the memory stage and its align helper.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 162;
  localparam int MS_TO_WS_BUS_WD = 122;
  localparam int MS_TO_DS_BUS_WD = 39;

  // Bit positions inside the 7-bit one-hot ld_op {lb,lbu,lh,lhu,lw,lwl,lwr}
  localparam int LD_LB  = 6;
  localparam int LD_LBU = 5;
  localparam int LD_LH  = 4;
  localparam int LD_LHU = 3;
  localparam int LD_LW  = 2;
  localparam int LD_LWL = 1;
  localparam int LD_LWR = 0;

  typedef struct packed {
    logic        exc_of;
    logic [31:0] badvaddr;
    logic        ades;
    logic        adel_if;
    logic        adel_ld;
    logic        ri;
    logic        bp;
    logic        flush;
    logic        bd;
    logic        eret;
    logic        sysc;
    logic        mfc0;
    logic        mtc0;
    logic [2:0]  sel;
    logic [4:0]  rd;
    logic        gpr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ms_ws_t;

  typedef struct packed {
    logic        req_issued;
    logic [6:0]  ld_op;
    logic [31:0] rt_value;
    ms_ws_t      ws;
  } es_ms_t;

  // Any exception that suppresses the memory access (eret is not one of them).
  function automatic logic exc_any(input ms_ws_t f);
    return f.exc_of | f.ades | f.adel_if | f.adel_ld | f.ri | f.bp | f.sysc;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: combinational load-data alignment and extension.
// Ports:
//   ld_op    one-hot {lb,lbu,lh,lhu,lw,lwl,lwr}
//   addr     low two bits of the effective address
//   rdata    raw 32-bit word returned by the data SRAM
//   rt_value old destination value, merged in by lwl/lwr
//   result   aligned, extended load result
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [6:0]  ld_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  input  logic [31:0] rt_value,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] lwl_val;
  logic [31:0] lwr_val;

  always_comb begin
    byte_sel = '0;
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = '0;
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    lwl_val = rdata;
    case (addr)
      2'd0: lwl_val = {rdata[7:0],  rt_value[23:0]};
      2'd1: lwl_val = {rdata[15:0], rt_value[15:0]};
      2'd2: lwl_val = {rdata[23:0], rt_value[7:0]};
      2'd3: lwl_val = rdata;
      default: lwl_val = rdata;
    endcase

    lwr_val = rdata;
    case (addr)
      2'd0: lwr_val = rdata;
      2'd1: lwr_val = {rt_value[31:24], rdata[31:8]};
      2'd2: lwr_val = {rt_value[31:16], rdata[31:16]};
      2'd3: lwr_val = {rt_value[31:8],  rdata[31:24]};
      default: lwr_val = rdata;
    endcase
  end

  always_comb begin
    result = rdata;
    unique case (1'b1)
      ld_op[LD_LB]:  result = {{24{byte_sel[7]}}, byte_sel};
      ld_op[LD_LBU]: result = {24'd0, byte_sel};
      ld_op[LD_LH]:  result = {{16{half_sel[15]}}, half_sel};
      ld_op[LD_LHU]: result = {16'd0, half_sel};
      ld_op[LD_LWL]: result = lwl_val;
      ld_op[LD_LWR]: result = lwr_val;
      default:       result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX and WB.
// Holds one instruction, waits for the data-SRAM data_ok of an issued request,
// aligns load data, buffers a response while WB stalls, and swallows responses
// whose instruction was flushed (drop_cnt).
// Ports:
//   clk, resetn            clock, async active-low reset
//   ms_allowin             MS can accept from EX
//   es_to_ms_valid/bus     incoming instruction (es_ms_t layout)
//   es_kill_outstanding    EX flushed with an unanswered request in flight
//   ws_allowin             WB can accept
//   ms_to_ws_valid/bus     outgoing result (ms_ws_t layout)
//   data_sram_data_ok/rdata SRAM response
//   exc_flush              exception/eret flush from WB
//   ms_ex_pending          valid instruction with exception or eret in MS
//   ms_to_ds_bus           forwarding {fwd_valid, fwd_blocked, dest, fwd_data}
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       es_kill_outstanding,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       exc_flush,
  output logic                       ms_ex_pending,
  output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus
);

  es_ms_t      ms_bus;
  logic        ms_valid;
  logic        buf_valid;
  logic [31:0] buf_data;
  logic [1:0]  drop_cnt;

  logic        need_data;
  logic        data_ok_eff;
  logic        ms_ready_go;
  logic        is_load;
  logic [31:0] rdata_src;
  logic [31:0] align_res;
  logic [31:0] final_res;
  logic        fwd_valid;
  logic        fwd_blocked;
  logic        handoff;
  ms_ws_t      ws_out;

  // drop_cnt update terms
  logic        inc_ms;
  logic        inc_kill;
  logic        dec;
  logic [2:0]  drop_sum;
  logic [1:0]  drop_next;

  assign need_data   = ms_bus.req_issued & ~exc_any(ms_bus.ws);
  // A response while drop_cnt!=0 belongs to a flushed instruction.
  assign data_ok_eff = data_sram_data_ok & (drop_cnt == 2'd0);
  assign ms_ready_go = ~need_data | data_ok_eff | buf_valid;

  assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin) | exc_flush;
  assign ms_to_ws_valid = ms_valid & ms_ready_go & ~exc_flush;
  assign handoff        = ms_to_ws_valid & ws_allowin;

  assign is_load   = |ms_bus.ld_op;
  assign rdata_src = buf_valid ? buf_data : data_sram_rdata;

  mem_load_align u_align (
    .ld_op    (ms_bus.ld_op),
    .addr     (ms_bus.ws.result[1:0]),
    .rdata    (rdata_src),
    .rt_value (ms_bus.rt_value),
    .result   (align_res)
  );

  assign final_res = is_load ? align_res : ms_bus.ws.result;

  always_comb begin
    ws_out        = ms_bus.ws;
    ws_out.result = final_res;
  end
  assign ms_to_ws_bus = ws_out;

  assign fwd_valid    = ms_valid & ms_bus.ws.gpr_we;
  assign fwd_blocked  = fwd_valid & (ms_bus.ws.mfc0 | (is_load & ~ms_ready_go));
  assign ms_to_ds_bus = {fwd_valid, fwd_blocked, ms_bus.ws.dest, final_res};

  assign ms_ex_pending = ms_valid & (exc_any(ms_bus.ws) | ms_bus.ws.eret);

  // On flush, MS owes a drop only if its own request is still unanswered this
  // cycle; a response arriving with the flush is consumed, not dropped later.
  assign inc_ms    = exc_flush & ms_valid & need_data & ~buf_valid & ~data_ok_eff;
  assign inc_kill  = exc_flush & es_kill_outstanding;
  assign dec       = data_sram_data_ok & (drop_cnt != 2'd0);
  assign drop_sum  = {1'b0, drop_cnt} + {2'b0, inc_ms} + {2'b0, inc_kill} - {2'b0, dec};
  assign drop_next = (drop_sum > 3'd2) ? 2'd2 : drop_sum[1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid  <= 1'b0;
      ms_bus    <= '0;
      buf_valid <= 1'b0;
      buf_data  <= '0;
      drop_cnt  <= 2'd0;
    end else begin
      if (exc_flush)       ms_valid <= 1'b0;
      else if (ms_allowin) ms_valid <= es_to_ms_valid;

      if (es_to_ms_valid & ms_allowin) ms_bus <= es_to_ms_bus;

      // Hold the response only when WB cannot take it in the same cycle.
      if (exc_flush | handoff) begin
        buf_valid <= 1'b0;
      end else if (data_ok_eff & ms_valid & need_data & ~buf_valid & ~ws_allowin) begin
        buf_valid <= 1'b1;
        buf_data  <= data_sram_rdata;
      end

      drop_cnt <= drop_next;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [161:0] es_to_ms_bus;
  logic         es_kill_outstanding;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [121:0] ms_to_ws_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         exc_flush;
  logic         ms_ex_pending;
  logic [38:0]  ms_to_ds_bus;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] OP_NONE = 7'b0000000;
  localparam logic [6:0] OP_LB   = 7'b1000000;
  localparam logic [6:0] OP_LHU  = 7'b0001000;
  localparam logic [6:0] OP_LW   = 7'b0000100;
  localparam logic [6:0] OP_LWL  = 7'b0000010;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk                 (clk),
    .resetn              (resetn),
    .ms_allowin          (ms_allowin),
    .es_to_ms_valid      (es_to_ms_valid),
    .es_to_ms_bus        (es_to_ms_bus),
    .es_kill_outstanding (es_kill_outstanding),
    .ws_allowin          (ws_allowin),
    .ms_to_ws_valid      (ms_to_ws_valid),
    .ms_to_ws_bus        (ms_to_ws_bus),
    .data_sram_data_ok   (data_sram_data_ok),
    .data_sram_rdata     (data_sram_rdata),
    .exc_flush           (exc_flush),
    .ms_ex_pending       (ms_ex_pending),
    .ms_to_ds_bus        (ms_to_ds_bus)
  );

  // Build an EX->MS word: gpr_we=1, dest=3 always.
  function automatic logic [161:0] mk(input logic req, input logic [6:0] ld,
                                      input logic [31:0] rt, input logic [31:0] res,
                                      input logic adel, input logic eret,
                                      input logic [31:0] pc);
    logic [161:0] b;
    b = '0;
    b[161] = req;
    b[160:154] = ld;
    b[153:122] = rt;
    b[86] = adel;
    b[81] = eret;
    b[69] = 1'b1;
    b[68:64] = 5'd3;
    b[63:32] = res;
    b[31:0] = pc;
    return b;
  endfunction

  // Called just after a posedge; returns just after the edge that loads MS.
  task automatic issue(input logic [161:0] b);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = b;
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    es_to_ms_valid = 0; es_to_ms_bus = '0; es_kill_outstanding = 0;
    ws_allowin = 1; data_sram_data_ok = 0; data_sram_rdata = '0; exc_flush = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (ms_allowin !== 1'b1) begin n_fail++; $display("FAIL reset_allowin got %b want 1", ms_allowin); end
    n_checks++;
    if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ws_valid got %b want 0", ms_to_ws_valid); end
    n_checks++;
    if (ms_ex_pending !== 1'b0) begin n_fail++; $display("FAIL reset_ex_pending got %b want 0", ms_ex_pending); end
    n_checks++;
    if (ms_to_ds_bus[38] !== 1'b0) begin n_fail++; $display("FAIL reset_fwd_valid got %b want 0", ms_to_ds_bus[38]); end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  // Load with data_ok in its first MS cycle, WB ready.
  task automatic load_once(input string name, input logic [6:0] op, input logic [31:0] addr,
                           input logic [31:0] rt, input logic [31:0] rd, input logic [31:0] exp);
    issue(mk(1'b1, op, rt, addr, 1'b0, 1'b0, 32'h0000_1000));
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rd;
    @(negedge clk);
    n_checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== exp) begin
      n_fail++;
      $display("FAIL %s valid=%b result=%h want valid=1 result=%h", name, ms_to_ws_valid, ms_to_ws_bus[63:32], exp);
    end
    n_checks++;
    if (ms_to_ds_bus[31:0] !== exp) begin
      n_fail++; $display("FAIL %s_fwd got %h want %h", name, ms_to_ds_bus[31:0], exp);
    end
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_align;
    load_once("lb_a3",   OP_LB,  32'h0000_0203, 32'h0,         32'h80FF_0011, 32'hFFFF_FF80);
    load_once("lhu_a2",  OP_LHU, 32'h0000_0202, 32'h0,         32'h80FF_0011, 32'h0000_80FF);
    load_once("lwl_a1",  OP_LWL, 32'h0000_0201, 32'hAABB_CCDD, 32'h80FF_0011, 32'h0011_CCDD);
  endtask

  task automatic test_wait;
    issue(mk(1'b1, OP_LW, 32'h0, 32'h0000_0100, 1'b0, 1'b0, 32'h0000_2000));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (ms_to_ws_valid !== 1'b0 || ms_to_ds_bus[37] !== 1'b1 || ms_allowin !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_cycle%0d valid=%b blocked=%b allowin=%b want 0,1,0", i, ms_to_ws_valid, ms_to_ds_bus[37], ms_allowin);
      end
      @(posedge clk); #1;
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1234_5678;
    @(negedge clk);
    n_checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h1234_5678 || ms_to_ds_bus[37] !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_done valid=%b result=%h blocked=%b want 1,12345678,0", ms_to_ws_valid, ms_to_ws_bus[63:32], ms_to_ds_bus[37]);
    end
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_buffer;
    issue(mk(1'b1, OP_LW, 32'h0, 32'h0000_0104, 1'b0, 1'b0, 32'h0000_3000));
    ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hCAFE_F00D;
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++;
    if (ms_allowin !== 1'b0 || ms_to_ws_bus[63:32] !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL buf_stall allowin=%b result=%h want 0,cafef00d", ms_allowin, ms_to_ws_bus[63:32]);
    end
    @(posedge clk); #1;
    ws_allowin = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b1 || ms_to_ws_bus[63:32] !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL buf_handoff valid=%b allowin=%b result=%h want 1,1,cafef00d", ms_to_ws_valid, ms_allowin, ms_to_ws_bus[63:32]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL buf_empty valid=%b want 0", ms_to_ws_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_drop;
    issue(mk(1'b1, OP_LW, 32'h0, 32'h0000_0108, 1'b0, 1'b0, 32'h0000_4000));
    exc_flush = 1'b1;
    es_kill_outstanding = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin
      n_fail++; $display("FAIL flush_outputs valid=%b allowin=%b want 0,1", ms_to_ws_valid, ms_allowin);
    end
    @(posedge clk); #1;
    exc_flush = 1'b0;
    es_kill_outstanding = 1'b0;
    n_checks++;
    if (dut.drop_cnt !== 2'd2) begin n_fail++; $display("FAIL drop_cnt got %0d want 2", dut.drop_cnt); end
    issue(mk(1'b1, OP_LW, 32'h0, 32'h0000_010C, 1'b0, 1'b0, 32'h0000_4004));
    for (int i = 0; i < 2; i++) begin
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'hBAD0_0000 + i;
      @(negedge clk);
      n_checks++;
      if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL drop_swallow%0d valid=%b want 0", i, ms_to_ws_valid); end
      @(posedge clk); #1;
    end
    data_sram_rdata = 32'h600D_0003;
    @(negedge clk);
    n_checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h600D_0003) begin
      n_fail++; $display("FAIL drop_third valid=%b result=%h want 1,600d0003", ms_to_ws_valid, ms_to_ws_bus[63:32]);
    end
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_exc;
    issue(mk(1'b0, OP_LW, 32'h0, 32'h0000_0111, 1'b1, 1'b0, 32'h0000_5000));
    @(negedge clk);
    n_checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_ex_pending !== 1'b1 || ms_to_ws_bus[86] !== 1'b1) begin
      n_fail++;
      $display("FAIL exc_pass valid=%b pending=%b adel=%b want 1,1,1", ms_to_ws_valid, ms_ex_pending, ms_to_ws_bus[86]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (ms_to_ws_valid !== 1'b0 || ms_ex_pending !== 1'b0) begin
      n_fail++; $display("FAIL exc_gone valid=%b pending=%b want 0,0", ms_to_ws_valid, ms_ex_pending);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(1'b0, OP_NONE, 32'h0, 32'h1111_1111, 1'b0, 1'b0, 32'h0000_6000);
    @(posedge clk); #1;
    es_to_ms_bus   = mk(1'b0, OP_NONE, 32'h0, 32'h2222_2222, 1'b0, 1'b0, 32'h0000_6004);
    @(negedge clk);
    n_checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h1111_1111 || ms_to_ds_bus !== {2'b10, 5'd3, 32'h1111_1111}) begin
      n_fail++;
      $display("FAIL b2b_first valid=%b result=%h ds=%h", ms_to_ws_valid, ms_to_ws_bus[63:32], ms_to_ds_bus);
    end
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h2222_2222 || ms_to_ws_bus[31:0] !== 32'h0000_6004) begin
      n_fail++;
      $display("FAIL b2b_second valid=%b result=%h pc=%h", ms_to_ws_valid, ms_to_ws_bus[63:32], ms_to_ws_bus[31:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    issue(mk(1'b1, OP_LW, 32'h0, 32'h0000_0120, 1'b0, 1'b1, 32'h0000_7000));
    @(negedge clk);
    n_checks++;
    if (ms_allowin !== 1'b0 || ms_ex_pending !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset allowin=%b pending=%b want 0,1", ms_allowin, ms_ex_pending);
    end
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if (ms_allowin !== 1'b1 || ms_to_ws_valid !== 1'b0 || ms_ex_pending !== 1'b0 || ms_to_ds_bus[38] !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset allowin=%b valid=%b pending=%b fwd=%b want 1,0,0,0", ms_allowin, ms_to_ws_valid, ms_ex_pending, ms_to_ds_bus[38]);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_align;
    test_wait;
    test_buffer;
    test_drop;
    test_exc;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
